// File: rtl/breakout_ball_ctrl.sv
// Ball motion controller: collects block-column bounce requests, applies them once per
// frame with wall/paddle reflection, and sequences serve/play/miss/game-over and lives.
module breakout_ball_ctrl #(
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 600,
  parameter int PADDLE_X    = 760,
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick_i,
  input  logic        launch_i,
  input  logic        hit_u_i,
  input  logic        hit_d_i,
  input  logic        hit_l_i,
  input  logic        hit_r_i,
  input  logic [10:0] paddle_y_t_i,
  input  logic [10:0] paddle_y_b_i,
  input  logic [10:0] pix_x_i,
  input  logic [10:0] pix_y_i,
  output logic [10:0] ball_x_l_o,
  output logic [10:0] ball_x_r_o,
  output logic [10:0] ball_y_t_o,
  output logic [10:0] ball_y_b_o,
  output logic        ball_on_o,
  output logic [1:0]  lives_o,
  output logic        miss_o,
  output logic        game_over_o
);

  localparam logic [11:0] BS       = 12'(BALL_SIZE);
  localparam logic [11:0] SP       = 12'(SPEED);
  localparam logic [11:0] PX       = 12'(PADDLE_X);
  localparam logic [11:0] XMAX     = 12'(SCREEN_W - 1);
  localparam logic [11:0] YMAX     = 12'(SCREEN_H - 1);
  localparam logic [11:0] YTOP_MAX = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [11:0] HALF     = 12'(BALL_SIZE / 2);
  localparam logic [10:0] X_SERVE  = 11'(PADDLE_X - BALL_SIZE);
  localparam logic [10:0] Y_RESET  = 11'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam int          CW       = $clog2(MISS_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS, S_GAMEOVER} state_e;

  state_e        state_q;
  logic [1:0]    lives_q;
  logic          dir_x_q, dir_y_q, miss_q;
  logic [10:0]   x_l_q, y_t_q;
  logic [3:0]    hit_q;            // {u, d, l, r}
  logic [CW-1:0] frame_cnt_q;

  logic [3:0]  hit_eff;
  logic        dir_x_h, dir_y_h, dir_x_d, dir_y_d, play_lost, paddle_hit;
  logic [11:0] x_l12, x_r12, y_t12, y_b12, paddle_sum, paddle_mid;
  logic [10:0] x_l_d, y_t_d, serve_y_t;

  // A pulse coincident with the tick counts for that tick.
  assign hit_eff = hit_q | {hit_u_i, hit_d_i, hit_l_i, hit_r_i};

  assign x_l12 = {1'b0, x_l_q};
  assign x_r12 = x_l12 + BS - 12'd1;
  assign y_t12 = {1'b0, y_t_q};
  assign y_b12 = y_t12 + BS - 12'd1;
  assign paddle_hit = (y_b12 >= {1'b0, paddle_y_t_i}) && (y_t12 <= {1'b0, paddle_y_b_i});
  assign paddle_sum = {1'b0, paddle_y_t_i} + {1'b0, paddle_y_b_i};
  assign paddle_mid = paddle_sum >> 1;

  always_comb begin
    dir_x_h = dir_x_q;
    if (hit_eff[0] && hit_eff[1])      dir_x_h = ~dir_x_q;
    else if (hit_eff[0])               dir_x_h = 1'b1;
    else if (hit_eff[1])               dir_x_h = 1'b0;
    dir_y_h = dir_y_q;
    if (hit_eff[2] && hit_eff[3])      dir_y_h = ~dir_y_q;
    else if (hit_eff[2])               dir_y_h = 1'b1;
    else if (hit_eff[3])               dir_y_h = 1'b0;
  end

  always_comb begin
    x_l_d     = x_l_q;
    dir_x_d   = dir_x_h;
    play_lost = 1'b0;
    if (!dir_x_h && (x_l12 < SP)) begin
      x_l_d   = '0;
      dir_x_d = 1'b1;
    end else if (dir_x_h && (x_r12 < PX) && (x_r12 + SP >= PX) && paddle_hit) begin
      x_l_d   = X_SERVE;
      dir_x_d = 1'b0;
    end else if (dir_x_h && (x_r12 + SP > XMAX)) begin
      play_lost = 1'b1;
    end else if (dir_x_h) begin
      x_l_d = 11'(x_l12 + SP);
    end else begin
      x_l_d = 11'(x_l12 - SP);
    end

    y_t_d   = y_t_q;
    dir_y_d = dir_y_h;
    if (!dir_y_h && (y_t12 < SP)) begin
      y_t_d   = '0;
      dir_y_d = 1'b1;
    end else if (dir_y_h && (y_b12 + SP > YMAX)) begin
      y_t_d   = 11'(YTOP_MAX);
      dir_y_d = 1'b0;
    end else if (dir_y_h) begin
      y_t_d = 11'(y_t12 + SP);
    end else begin
      y_t_d = 11'(y_t12 - SP);
    end

    if (paddle_mid < HALF)                   serve_y_t = '0;
    else if (paddle_mid - HALF > YTOP_MAX)   serve_y_t = 11'(YTOP_MAX);
    else                                     serve_y_t = 11'(paddle_mid - HALF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SERVE;
      lives_q     <= 2'(LIVES);
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      x_l_q       <= X_SERVE;
      y_t_q       <= Y_RESET;
      miss_q      <= 1'b0;
      hit_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      miss_q <= 1'b0;
      if (frame_tick_i)
        hit_q <= '0;
      else if (state_q == S_PLAY)
        hit_q <= hit_eff;
      if (frame_tick_i) begin
        case (state_q)
          S_SERVE: begin
            x_l_q <= X_SERVE;
            y_t_q <= serve_y_t;
            if (launch_i) begin
              state_q <= S_PLAY;
              dir_x_q <= 1'b0;
              dir_y_q <= 1'b0;
            end
          end
          S_PLAY: begin
            if (play_lost) begin
              // Ball freezes where it left the field; only the hit-applied directions stick.
              dir_x_q     <= dir_x_h;
              dir_y_q     <= dir_y_h;
              state_q     <= S_MISS;
              miss_q      <= 1'b1;
              lives_q     <= (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
              frame_cnt_q <= '0;
            end else begin
              dir_x_q <= dir_x_d;
              dir_y_q <= dir_y_d;
              x_l_q   <= x_l_d;
              y_t_q   <= y_t_d;
            end
          end
          S_MISS: begin
            if (frame_cnt_q == CNT_LAST)
              state_q <= (lives_q == 2'd0) ? S_GAMEOVER : S_SERVE;
            else
              frame_cnt_q <= frame_cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ball_x_l_o  = x_l_q;
  assign ball_x_r_o  = 11'(x_r12);
  assign ball_y_t_o  = y_t_q;
  assign ball_y_b_o  = 11'(y_b12);
  assign lives_o     = lives_q;
  assign miss_o      = miss_q;
  assign game_over_o = (state_q == S_GAMEOVER);
  assign ball_on_o   = (state_q != S_GAMEOVER) &&
                       ({1'b0, pix_x_i} >= x_l12) && ({1'b0, pix_x_i} <= x_r12) &&
                       ({1'b0, pix_y_i} >= y_t12) && ({1'b0, pix_y_i} <= y_b12);

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// Self-checking bench for breakout_ball_ctrl: vector table plus hand-written miss,
// game-over and reset sequences, all routed through an expectation queue.
module tb_breakout_ball_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, frame_tick, launch, hit_u, hit_d, hit_l, hit_r;
  logic [10:0] paddle_y_t, paddle_y_b, pix_x, pix_y;
  logic [10:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
  logic        ball_on, miss, game_over;
  logic [1:0]  lives;

  breakout_ball_ctrl #(.MISS_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .frame_tick_i(frame_tick), .launch_i(launch),
    .hit_u_i(hit_u), .hit_d_i(hit_d), .hit_l_i(hit_l), .hit_r_i(hit_r),
    .paddle_y_t_i(paddle_y_t), .paddle_y_b_i(paddle_y_b),
    .pix_x_i(pix_x), .pix_y_i(pix_y),
    .ball_x_l_o(ball_x_l), .ball_x_r_o(ball_x_r), .ball_y_t_o(ball_y_t), .ball_y_b_o(ball_y_b),
    .ball_on_o(ball_on), .lives_o(lives), .miss_o(miss), .game_over_o(game_over)
  );

  typedef struct {
    string name; int pre; logic tk; logic ln; logic [3:0] h;
    logic [10:0] pt, pb, px, py, xl, yt; logic [1:0] lv; logic ms, go, bon;
  } vec_t;
  typedef struct {
    string name; logic [10:0] xl, yt; logic [1:0] lv; logic ms, go, bon;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic add(input string nm, input int pre, input logic tk, input logic ln,
                     input logic [3:0] h, input int pt, input int pb, input int px, input int py,
                     input int xl, input int yt, input int lv, input int ms, input int go,
                     input int bon);
    vec_t v;
    v.name = nm; v.pre = pre; v.tk = tk; v.ln = ln; v.h = h;
    v.pt = 11'(pt); v.pb = 11'(pb); v.px = 11'(px); v.py = 11'(py);
    v.xl = 11'(xl); v.yt = 11'(yt); v.lv = 2'(lv);
    v.ms = 1'(ms); v.go = 1'(go); v.bon = 1'(bon);
    vt.push_back(v);
  endtask

  task automatic expect_v(input string nm, input int xl, input int yt, input int lv,
                          input int ms, input int go, input int bon);
    exp_t e;
    e.name = nm; e.xl = 11'(xl); e.yt = 11'(yt); e.lv = 2'(lv);
    e.ms = 1'(ms); e.go = 1'(go); e.bon = 1'(bon);
    sb.push_back(e);
  endtask

  task automatic cyc(input logic tk, input logic ln, input logic [3:0] h, input logic rst);
    @(negedge clk);
    frame_tick = tk; launch = ln; {hit_u, hit_d, hit_l, hit_r} = h; reset = rst;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; launch = 1'b0; {hit_u, hit_d, hit_l, hit_r} = 4'b0; reset = 1'b0;
  endtask

  task automatic check();
    exp_t e;
    logic [48:0] got, want;
    nvec++;
    if (sb.size() == 0) begin
      nmis++;
      $display("FAIL scoreboard_empty: got x_l=%0d, required a queued expectation", ball_x_l);
      return;
    end
    e = sb.pop_front();
    got  = {ball_x_l, ball_x_r, ball_y_t, ball_y_b, lives, miss, game_over, ball_on};
    want = {e.xl, 11'(e.xl + 11'd7), e.yt, 11'(e.yt + 11'd7), e.lv, e.ms, e.go, e.bon};
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got x_l=%0d x_r=%0d y_t=%0d y_b=%0d lives=%0d miss=%b go=%b on=%b | exp x_l=%0d x_r=%0d y_t=%0d y_b=%0d lives=%0d miss=%b go=%b on=%b",
               e.name, ball_x_l, ball_x_r, ball_y_t, ball_y_b, lives, miss, game_over, ball_on,
               e.xl, e.xl + 11'd7, e.yt, e.yt + 11'd7, e.lv, e.ms, e.go, e.bon);
    end else begin
      $display("ok   %s: x_l=%0d y_t=%0d lives=%0d miss=%b go=%b on=%b",
               e.name, ball_x_l, ball_y_t, lives, miss, game_over, ball_on);
    end
  endtask

  task automatic step(input string nm, input logic tk, input logic ln, input logic [3:0] h,
                      input int xl, input int yt, input int lv, input int ms, input int go,
                      input int bon);
    expect_v(nm, xl, yt, lv, ms, go, bon);
    cyc(tk, ln, h, 1'b0);
    check();
  endtask

  task automatic silent(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic set_paddle(input int t, input int b);
    paddle_y_t = 11'(t); paddle_y_b = 11'(b);
  endtask

  // Serve, launch rightwards with the paddle out of the way, and lose the ball.
  task automatic lose_ball(input int lv);
    set_paddle(400, 463);
    pix_x = 11'd0; pix_y = 11'd599;
    step("relaunch", 1'b1, 1'b1, 4'b0, 752, 427, lv, 0, 0, 0);
    set_paddle(0, 63);
    step("relaunch_hit_r", 1'b0, 1'b0, 4'b0001, 752, 427, lv, 0, 0, 0);
    step("heading_right", 1'b1, 1'b0, 4'b0, 754, 425, lv, 0, 0, 0);
    silent(18);
    step("right_limit_again", 1'b1, 1'b0, 4'b0, 792, 387, lv, 0, 0, 0);
    step("miss_again", 1'b1, 1'b0, 4'b0, 792, 387, lv - 1, 1, 0, 0);
    step("miss_frame1_again", 1'b1, 1'b0, 4'b0, 792, 387, lv - 1, 0, 0, 0);
    if (lv > 1) begin
      step("back_to_serve", 1'b1, 1'b0, 4'b0, 792, 387, lv - 1, 0, 0, 0);
      set_paddle(400, 463);
      step("serve_track_again", 1'b1, 1'b0, 4'b0, 752, 427, lv - 1, 0, 0, 0);
    end else begin
      pix_x = 11'd795; pix_y = 11'd390;
      step("game_over_entry", 1'b1, 1'b0, 4'b0, 792, 387, 0, 0, 1, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; launch = 1'b0;
    {hit_u, hit_d, hit_l, hit_r} = 4'b0;
    set_paddle(280, 343);
    pix_x = 11'd0; pix_y = 11'd599;

    //   name                   pre tk ln hits     pt   pb   px   py   x_l  y_t lv ms go on
    add("reset_state",           0, 1'b0, 1'b0, 4'b0000, 280, 343, 752, 296, 752, 296, 3, 0, 0, 1);
    add("serve_track",           0, 1'b1, 1'b0, 4'b0000, 280, 343, 759, 303, 752, 307, 3, 0, 0, 0);
    add("serve_stable_corner",   0, 1'b0, 1'b0, 4'b0000, 280, 343, 759, 314, 752, 307, 3, 0, 0, 1);
    add("launch_no_move",        0, 1'b1, 1'b1, 4'b0000, 280, 343,   0, 599, 752, 307, 3, 0, 0, 0);
    add("play_first_step",       0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599, 750, 305, 3, 0, 0, 0);
    add("approach_top",        151, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599, 446,   1, 3, 0, 0, 0);
    add("top_wall_clamp",        0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599, 444,   0, 3, 0, 0, 0);
    add("top_wall_bounce",       0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599, 442,   2, 3, 0, 0, 0);
    add("reach_x50",           195, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599,  50, 394, 3, 0, 0, 0);
    add("hit_r_midframe_hold",   0, 1'b0, 1'b0, 4'b0001, 280, 343,   0, 599,  50, 394, 3, 0, 0, 0);
    add("hit_r_applied",         0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599,  52, 396, 3, 0, 0, 0);
    add("dir_x_persists",        0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599,  54, 398, 3, 0, 0, 0);
    add("hit_l_pulse",           0, 1'b0, 1'b0, 4'b0010, 280, 343,   0, 599,  54, 398, 3, 0, 0, 0);
    add("hit_r_pulse",           0, 1'b0, 1'b0, 4'b0001, 280, 343,   0, 599,  54, 398, 3, 0, 0, 0);
    add("hit_lr_invert",         0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599,  52, 400, 3, 0, 0, 0);
    add("move_left",             0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599,  50, 402, 3, 0, 0, 0);
    add("hit_u_on_tick",         0, 1'b1, 1'b0, 4'b1000, 280, 343,   0, 599,  48, 400, 3, 0, 0, 0);
    add("hit_u_pulse",           0, 1'b0, 1'b0, 4'b1000, 280, 343,   0, 599,  48, 400, 3, 0, 0, 0);
    add("hit_d_pulse",           0, 1'b0, 1'b0, 4'b0100, 280, 343,   0, 599,  48, 400, 3, 0, 0, 0);
    add("hit_d_repeat",          0, 1'b0, 1'b0, 4'b0100, 280, 343,   0, 599,  48, 400, 3, 0, 0, 0);
    add("hit_ud_invert",         0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599,  46, 402, 3, 0, 0, 0);
    add("left_wall_reach",      22, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 448,   0, 448, 3, 0, 0, 1);
    add("left_wall_clamp",       0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599,   0, 450, 3, 0, 0, 0);
    add("left_wall_rise",        0, 1'b1, 1'b0, 4'b0000, 280, 343,   1, 452,   2, 452, 3, 0, 0, 0);
    add("near_paddle",         373, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599, 750,  12, 3, 0, 0, 0);
    add("at_paddle_face",        0, 1'b1, 1'b0, 4'b0000, 280, 343,   0, 599, 752,  14, 3, 0, 0, 0);
    add("paddle_bounce",         0, 1'b1, 1'b0, 4'b0000,   0,  63,   0, 599, 752,  16, 3, 0, 0, 0);
    add("after_bounce",          0, 1'b1, 1'b0, 4'b0000,   0,  63,   0, 599, 750,  18, 3, 0, 0, 0);
    add("hit_r_paddle_away",     0, 1'b0, 1'b0, 4'b0001, 400, 463,   0, 599, 750,  18, 3, 0, 0, 0);
    add("toward_edge",           0, 1'b1, 1'b0, 4'b0000, 400, 463,   0, 599, 752,  20, 3, 0, 0, 0);
    add("right_limit",          19, 1'b1, 1'b0, 4'b0000, 400, 463,   0, 599, 792,  60, 3, 0, 0, 0);
    add("miss_entry",            0, 1'b1, 1'b0, 4'b0000, 400, 463, 799,  67, 792,  60, 2, 1, 0, 1);
    add("miss_pulse_ends",       0, 1'b0, 1'b0, 4'b0000, 400, 463, 799,  67, 792,  60, 2, 0, 0, 1);
    add("miss_frame1",           0, 1'b1, 1'b0, 4'b0000, 400, 463,   0, 599, 792,  60, 2, 0, 0, 0);
    add("miss_to_serve",         0, 1'b1, 1'b0, 4'b0000, 400, 463,   0, 599, 792,  60, 2, 0, 0, 0);
    add("reserve_track",         0, 1'b1, 1'b0, 4'b0000, 400, 463,   0, 599, 752, 427, 2, 0, 0, 0);

    cyc(1'b0, 1'b0, 4'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'b0, 1'b1);

    foreach (vt[i]) begin
      set_paddle(int'(vt[i].pt), int'(vt[i].pb));
      silent(vt[i].pre);
      pix_x = vt[i].px; pix_y = vt[i].py;
      expect_v(vt[i].name, int'(vt[i].xl), int'(vt[i].yt), int'(vt[i].lv),
               int'(vt[i].ms), int'(vt[i].go), int'(vt[i].bon));
      cyc(vt[i].tk, vt[i].ln, vt[i].h, 1'b0);
      check();
    end

    lose_ball(2);
    lose_ball(1);
    step("go_ignore_hits", 1'b0, 1'b0, 4'b1111, 792, 387, 0, 0, 1, 0);
    step("go_ignore_tick", 1'b1, 1'b1, 4'b0001, 792, 387, 0, 0, 1, 0);

    // Reset out of GAMEOVER, then reset in PLAY with a hit pending.
    pix_x = 11'd0; pix_y = 11'd599;
    expect_v("reset_from_gameover", 752, 296, 3, 0, 0, 0);
    cyc(1'b0, 1'b0, 4'b0, 1'b1);
    check();
    set_paddle(280, 343);
    step("serve_after_reset", 1'b1, 1'b0, 4'b0, 752, 307, 3, 0, 0, 0);
    step("launch_after_reset", 1'b1, 1'b1, 4'b0, 752, 307, 3, 0, 0, 0);
    step("play_after_reset", 1'b1, 1'b0, 4'b0, 750, 305, 3, 0, 0, 0);
    step("pending_hit_d", 1'b0, 1'b0, 4'b0100, 750, 305, 3, 0, 0, 0);
    expect_v("reset_mid_play", 752, 296, 3, 0, 0, 0);
    cyc(1'b0, 1'b0, 4'b0, 1'b1);
    check();
    step("post_reset_serve", 1'b1, 1'b0, 4'b0, 752, 307, 3, 0, 0, 0);
    step("post_reset_launch", 1'b1, 1'b1, 4'b0, 752, 307, 3, 0, 0, 0);
    step("hit_discarded", 1'b1, 1'b0, 4'b0, 750, 305, 3, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
